// File: rtl/cve2_mem_arbiter.sv
// rtl/cve2_mem_arbiter.sv - merges instr-fetch and load/store requests onto one shared memory port
// The chosen master is held until granted; an in-order owner FIFO routes each rvalid back to its issuer.
module cve2_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic [2:0]  outstanding_o,
  output logic        busy_o,
  output logic        unexp_rvalid_o
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] LOCKED   = 1'b1;
  localparam logic [2:0] DEPTH    = 3'(MaxOutstanding);
  localparam logic [1:0] LAST_IDX = 2'(MaxOutstanding - 1);

  logic [0:0] state;
  logic       owner;      // master held while LOCKED: 0 = instr, 1 = data
  logic       rr_data;    // round-robin preference: 1 = data wins the next tie
  logic [3:0] fifo;
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       unexp;

  logic full;
  logic sel_valid;
  logic sel;
  logic sel_req;
  logic push;
  logic pop;
  logic head;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
  endfunction

  // Full is registered state only, so a same-cycle pop never reopens issue.
  assign full = (count == DEPTH);

  always_comb begin
    sel_valid = 1'b0;
    sel       = 1'b0;
    if (full) begin
      sel_valid = 1'b0;
    end else if (state == LOCKED) begin
      sel_valid = 1'b1;
      sel       = owner;
    end else if (instr_req_i && data_req_i) begin
      sel_valid = 1'b1;
      sel       = DataPriority ? 1'b1 : rr_data;
    end else if (data_req_i) begin
      sel_valid = 1'b1;
      sel       = 1'b1;
    end else if (instr_req_i) begin
      sel_valid = 1'b1;
      sel       = 1'b0;
    end
  end

  assign sel_req   = sel ? data_req_i : instr_req_i;
  assign mem_req_o = sel_valid & sel_req;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (sel_valid) begin
      if (sel) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  assign push        = mem_gnt_i & mem_req_o;
  assign instr_gnt_o = push & ~sel;
  assign data_gnt_o  = push & sel;

  assign pop  = mem_rvalid_i & (count != 3'd0);
  assign head = fifo[rd_ptr];

  assign instr_rvalid_o = pop & ~head;
  assign data_rvalid_o  = pop & head;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i & instr_rvalid_o;
  assign data_err_o     = mem_err_i & data_rvalid_o;

  assign outstanding_o  = count;
  assign busy_o         = instr_req_i | data_req_i | (count != 3'd0);
  assign unexp_rvalid_o = unexp;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      owner   <= 1'b0;
      rr_data <= 1'b1;
      fifo    <= 4'h0;
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      count   <= 3'd0;
      unexp   <= 1'b0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= sel;
        wr_ptr       <= next_ptr(wr_ptr);
        rr_data      <= ~sel;
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (mem_rvalid_i && (count == 3'd0)) begin
        unexp <= 1'b1;
      end
      // An owner dropping its request while locked abandons it without a push.
      if (state == IDLE) begin
        if (mem_req_o && !mem_gnt_i) begin
          state <= LOCKED;
          owner <= sel;
        end
      end else if (mem_gnt_i || !sel_req) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// tb/tb_cve2_mem_arbiter.sv - self-checking bench for cve2_mem_arbiter
// Instance 0 uses data priority, instance 1 round-robin; both share stimulus and a queue-based model.
module tb_cve2_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, instr_req, data_req, data_we, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_be;

  logic [1:0]        instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err;
  logic [1:0]        mem_req, mem_we, busy, unexp;
  logic [1:0][31:0]  instr_rdata, data_rdata, mem_addr, mem_wdata;
  logic [1:0][3:0]   mem_be;
  logic [1:0][2:0]   outstanding;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cve2_mem_arbiter #(
      .MaxOutstanding(2),
      .DataPriority  (g == 0 ? 1'b1 : 1'b0)
    ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .instr_req_i   (instr_req),
      .instr_addr_i  (instr_addr),
      .instr_gnt_o   (instr_gnt[g]),
      .instr_rvalid_o(instr_rvalid[g]),
      .instr_rdata_o (instr_rdata[g]),
      .instr_err_o   (instr_err[g]),
      .data_req_i    (data_req),
      .data_we_i     (data_we),
      .data_be_i     (data_be),
      .data_addr_i   (data_addr),
      .data_wdata_i  (data_wdata),
      .data_gnt_o    (data_gnt[g]),
      .data_rvalid_o (data_rvalid[g]),
      .data_rdata_o  (data_rdata[g]),
      .data_err_o    (data_err[g]),
      .mem_req_o     (mem_req[g]),
      .mem_gnt_i     (mem_gnt),
      .mem_we_o      (mem_we[g]),
      .mem_be_o      (mem_be[g]),
      .mem_addr_o    (mem_addr[g]),
      .mem_wdata_o   (mem_wdata[g]),
      .mem_rvalid_i  (mem_rvalid),
      .mem_rdata_i   (mem_rdata),
      .mem_err_i     (mem_err),
      .outstanding_o (outstanding[g]),
      .busy_o        (busy[g]),
      .unexp_rvalid_o(unexp[g])
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: issued-owner queue, held request, tie preference and sticky flag per instance.
  bit oq [2][$];
  bit m_held [2];
  bit m_held_owner [2];
  bit m_pref_data [2];
  bit m_unexp [2];

  task automatic model_step(input bit check_en);
    for (int g = 0; g < 2; g++) begin
      int occ;
      bit have, sel, oreq, req, gnt, pop, head, irv, drv;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_be;
      logic [9:0]  e_ctrl, a_ctrl;
      occ  = oq[g].size();
      have = 1'b0;
      sel  = 1'b0;
      if (occ >= 2) have = 1'b0;
      else if (m_held[g]) begin have = 1'b1; sel = m_held_owner[g]; end
      else if (instr_req && data_req) begin have = 1'b1; sel = (g == 0) ? 1'b1 : m_pref_data[g]; end
      else if (data_req) begin have = 1'b1; sel = 1'b1; end
      else if (instr_req) begin have = 1'b1; sel = 1'b0; end
      oreq    = sel ? data_req : instr_req;
      req     = have && oreq;
      e_addr  = !have ? 32'h0 : (sel ? data_addr : instr_addr);
      e_be    = !have ? 4'h0 : (sel ? data_be : 4'hF);
      e_wdata = (have && sel) ? data_wdata : 32'h0;
      gnt     = req && mem_gnt;
      pop     = mem_rvalid && (occ > 0);
      head    = pop ? oq[g][0] : 1'b0;
      irv     = pop && !head;
      drv     = pop && head;
      if (check_en) begin
        e_ctrl = {req, have && sel && data_we, gnt && !sel, gnt && sel, irv, drv,
                  mem_err && irv, mem_err && drv, instr_req || data_req || occ != 0, m_unexp[g]};
        a_ctrl = {mem_req[g], mem_we[g], instr_gnt[g], data_gnt[g], instr_rvalid[g], data_rvalid[g],
                  instr_err[g], data_err[g], busy[g], unexp[g]};
        chk($sformatf("dut%0d ctrl{req,we,ig,dg,irv,drv,ierr,derr,busy,unexp}", g), 32'(a_ctrl), 32'(e_ctrl));
        chk($sformatf("dut%0d mem_addr", g), mem_addr[g], e_addr);
        chk($sformatf("dut%0d mem_be", g), 32'(mem_be[g]), 32'(e_be));
        chk($sformatf("dut%0d mem_wdata", g), mem_wdata[g], e_wdata);
        chk($sformatf("dut%0d instr_rdata", g), instr_rdata[g], mem_rdata);
        chk($sformatf("dut%0d data_rdata", g), data_rdata[g], mem_rdata);
        chk($sformatf("dut%0d outstanding", g), 32'(outstanding[g]), 32'(occ));
      end
      if (rst) begin
        oq[g].delete();
        m_held[g]      = 1'b0;
        m_pref_data[g] = 1'b1;
        m_unexp[g]     = 1'b0;
      end else begin
        if (mem_rvalid && occ == 0) m_unexp[g] = 1'b1;
        if (pop) void'(oq[g].pop_front());
        if (gnt) begin
          oq[g].push_back(sel);
          m_pref_data[g] = !sel;
        end
        if (!m_held[g]) begin
          if (req && !mem_gnt) begin
            m_held[g]       = 1'b1;
            m_held_owner[g] = sel;
          end
        end else if (mem_gnt || !oreq) begin
          m_held[g] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    #4;
    model_step(1'b1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          rst, ireq, dreq, gnt, rv, err;
    logic [31:0] iaddr, daddr, rdata;
    int          dut;
    bit          req, ig, dg, irv, drv, ux;
    logic [31:0] addr;
    logic [2:0]  occ;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input bit r, input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                     input bit gn, input bit rv, input logic [31:0] rd, input bit er, input int dut,
                     input bit req, input bit ig, input bit dg, input logic [31:0] ad,
                     input bit irv, input bit drv, input logic [2:0] occ, input bit ux);
    vec_t v;
    v.rst = r; v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.daddr = da;
    v.gnt = gn; v.rv = rv; v.rdata = rd; v.err = er; v.dut = dut;
    v.req = req; v.ig = ig; v.dg = dg; v.addr = ad; v.irv = irv; v.drv = drv; v.occ = occ; v.ux = ux;
    tbl.push_back(v);
  endtask

  localparam logic [31:0] IA = 32'h100;
  localparam logic [31:0] DA = 32'h200;

  initial begin
    rst = 1'b1; instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_err = 1'b0; instr_addr = '0; data_addr = '0; data_wdata = '0;
    mem_rdata = '0; data_be = '0;
    model_step(1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Data priority: data wins until full, pop does not unblock the same cycle.
    add(0, 0, 0,  0, 0,  0, 0, 0, 0,             0, 0, 0, 0, 0,  0, 0, 0, 0);
    add(0, 1, IA, 1, DA, 1, 0, 0, 0,             0, 1, 0, 1, DA, 0, 0, 0, 0);
    add(0, 1, IA, 1, DA, 1, 0, 0, 0,             0, 1, 0, 1, DA, 0, 0, 1, 0);
    add(0, 1, IA, 1, DA, 1, 0, 0, 0,             0, 0, 0, 0, 0,  0, 0, 2, 0);
    add(0, 1, IA, 0, DA, 1, 1, 32'hDEADBEEF, 1,  0, 0, 0, 0, 0,  0, 1, 2, 0);
    add(0, 1, IA, 0, DA, 1, 0, 0, 0,             0, 1, 1, 0, IA, 0, 0, 1, 0);
    add(0, 0, 0,  0, 0,  0, 1, 32'h13, 0,        0, 0, 0, 0, 0,  0, 1, 2, 0);
    add(0, 0, 0,  0, 0,  0, 1, 32'h14, 0,        0, 0, 0, 0, 0,  1, 0, 1, 0);
    add(0, 0, 0,  0, 0,  0, 0, 0, 0,             0, 0, 0, 0, 0,  0, 0, 0, 0);
    // Stalled instr request stays selected while data arrives.
    add(0, 1, IA, 0, 0,  0, 0, 0, 0,             0, 1, 0, 0, IA, 0, 0, 0, 0);
    add(0, 1, IA, 1, DA, 0, 0, 0, 0,             0, 1, 0, 0, IA, 0, 0, 0, 0);
    add(0, 1, IA, 1, DA, 0, 0, 0, 0,             0, 1, 0, 0, IA, 0, 0, 0, 0);
    add(0, 1, IA, 1, DA, 1, 0, 0, 0,             0, 1, 1, 0, IA, 0, 0, 0, 0);
    add(0, 0, IA, 1, DA, 1, 0, 0, 0,             0, 1, 0, 1, DA, 0, 0, 1, 0);
    add(0, 0, 0,  0, 0,  0, 1, 32'h5, 0,         0, 0, 0, 0, 0,  1, 0, 2, 0);
    add(0, 0, 0,  0, 0,  0, 1, 32'h6, 0,         0, 0, 0, 0, 0,  0, 1, 1, 0);
    add(0, 0, 0,  0, 0,  0, 0, 0, 0,             0, 0, 0, 0, 0,  0, 0, 0, 0);
    // Round-robin instance: data first after reset, then alternating.
    add(1, 0, 0,  0, 0,  0, 0, 0, 0,             1, 0, 0, 0, 0,  0, 0, 0, 0);
    add(0, 1, IA, 1, DA, 1, 0, 0, 0,             1, 1, 0, 1, DA, 0, 0, 0, 0);
    add(0, 1, IA, 1, DA, 1, 1, 32'hA, 0,         1, 1, 1, 0, IA, 0, 1, 1, 0);
    add(0, 1, IA, 1, DA, 1, 1, 32'hB, 0,         1, 1, 0, 1, DA, 1, 0, 1, 0);
    add(0, 1, IA, 1, DA, 1, 1, 32'hC, 0,         1, 1, 1, 0, IA, 0, 1, 1, 0);
    add(0, 0, 0,  0, 0,  0, 1, 32'hD, 0,         1, 0, 0, 0, 0,  1, 0, 1, 0);
    add(0, 0, 0,  0, 0,  0, 0, 0, 0,             1, 0, 0, 0, 0,  0, 0, 0, 0);
    // Reset with one outstanding, then a stray rvalid sets the sticky flag.
    add(0, 0, 0,  1, DA, 1, 0, 0, 0,             0, 1, 0, 1, DA, 0, 0, 0, 0);
    add(1, 0, 0,  0, 0,  0, 0, 0, 0,             0, 0, 0, 0, 0,  0, 0, 1, 0);
    add(0, 0, 0,  0, 0,  0, 1, 32'h77, 0,        0, 0, 0, 0, 0,  0, 0, 0, 0);
    add(0, 0, 0,  0, 0,  0, 0, 0, 0,             0, 0, 0, 0, 0,  0, 0, 0, 1);
    add(0, 0, 0,  0, 0,  0, 0, 0, 0,             0, 0, 0, 0, 0,  0, 0, 0, 1);
    add(1, 0, 0,  0, 0,  0, 0, 0, 0,             0, 0, 0, 0, 0,  0, 0, 0, 1);
    add(0, 0, 0,  0, 0,  0, 0, 0, 0,             0, 0, 0, 0, 0,  0, 0, 0, 0);

    data_we = 1'b1; data_be = 4'h3; data_wdata = 32'hCAFE;
    for (int i = 0; i < tbl.size(); i++) begin
      int d;
      d = tbl[i].dut;
      rst = tbl[i].rst; instr_req = tbl[i].ireq; instr_addr = tbl[i].iaddr;
      data_req = tbl[i].dreq; data_addr = tbl[i].daddr; mem_gnt = tbl[i].gnt;
      mem_rvalid = tbl[i].rv; mem_rdata = tbl[i].rdata; mem_err = tbl[i].err;
      #4;
      chk($sformatf("row%0d mem_req", i), 32'(mem_req[d]), 32'(tbl[i].req));
      chk($sformatf("row%0d instr_gnt", i), 32'(instr_gnt[d]), 32'(tbl[i].ig));
      chk($sformatf("row%0d data_gnt", i), 32'(data_gnt[d]), 32'(tbl[i].dg));
      chk($sformatf("row%0d mem_addr", i), mem_addr[d], tbl[i].addr);
      chk($sformatf("row%0d instr_rvalid", i), 32'(instr_rvalid[d]), 32'(tbl[i].irv));
      chk($sformatf("row%0d data_rvalid", i), 32'(data_rvalid[d]), 32'(tbl[i].drv));
      chk($sformatf("row%0d outstanding", i), 32'(outstanding[d]), 32'(tbl[i].occ));
      chk($sformatf("row%0d unexp_rvalid", i), 32'(unexp[d]), 32'(tbl[i].ux));
      model_step(1'b1);
      @(posedge clk);
      #1;
    end

    // Error and data routed to the data master, then the instr response.
    rst = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    instr_req = 1'b1; data_req = 1'b1; mem_gnt = 1'b1;
    tick();
    data_req = 1'b0;
    tick();
    instr_req = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; mem_err = 1'b1;
    #4;
    chk("err seq data_rvalid", 32'(data_rvalid[0]), 32'd1);
    chk("err seq data_err", 32'(data_err[0]), 32'd1);
    chk("err seq data_rdata", data_rdata[0], 32'hDEADBEEF);
    chk("err seq instr_rvalid", 32'(instr_rvalid[0]), 32'd0);
    chk("err seq instr_err", 32'(instr_err[0]), 32'd0);
    model_step(1'b1);
    @(posedge clk);
    #1;
    mem_rdata = 32'h13; mem_err = 1'b0;
    #4;
    chk("err seq instr_rvalid 2", 32'(instr_rvalid[0]), 32'd1);
    chk("err seq instr_rdata", instr_rdata[0], 32'h13);
    chk("err seq data_rvalid 2", 32'(data_rvalid[0]), 32'd0);
    model_step(1'b1);
    @(posedge clk);
    #1;

    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      instr_req  = ($urandom_range(0, 2) != 0);
      data_req   = ($urandom_range(0, 2) != 0);
      data_we    = 1'($urandom);
      data_be    = 4'($urandom);
      instr_addr = $urandom;
      data_addr  = $urandom;
      data_wdata = $urandom;
      mem_gnt    = ($urandom_range(0, 9) < 6);
      mem_rvalid = ($urandom_range(0, 9) < 4);
      mem_rdata  = $urandom;
      mem_err    = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
